// File: rtl/spi_ram_responder_if.sv
// SPI bus between the core (master) and the RAM responder (slave).
interface spi_ram_responder_if;
  logic spi_select;
  logic spi_clk_enable;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_select, spi_clk_enable, spi_mosi, input spi_miso);
  modport slave  (input spi_select, spi_clk_enable, spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_ram_responder.sv
// SPI RAM responder: read (03), fast read (0B), write (02) on a small byte memory,
// single clock domain with spi_clk_enable qualifying each bit cycle.
module spi_ram_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  spi_ram_responder_if.slave   spi,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 busy
);
  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DUMMY, S_RD, S_WR, S_IGN} state_e;
  typedef enum logic [1:0] {K_RD, K_FAST, K_WR} kind_e;
  localparam int CW = (DUMMY_CYCLES > 24) ? $clog2(DUMMY_CYCLES + 1) : 5;

  state_e               state_q, state_d;
  kind_e                kind_q, kind_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [6:0]           sh_q, sh_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 armed_q, armed_d;

  logic [7:0]           mem [2**ADDR_BITS];
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_wa;
  logic [7:0]           mem_wd;

  logic                 bit_cyc, last8;
  logic [7:0]           sh_in;

  // After reset, bit cycles are ignored until a deselect has been seen, so a
  // select held low across reset can never resume the aborted transfer.
  assign bit_cyc = armed_q && !spi.spi_select && spi.spi_clk_enable;
  assign sh_in   = {sh_q, spi.spi_mosi};
  assign last8   = (cnt_q == CW'(7));

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    armed_d = armed_q | spi.spi_select;
    mem_we  = 1'b0;
    mem_wa  = addr_q;
    mem_wd  = sh_in;
    if (spi.spi_select) begin
      state_d = S_CMD;
      cnt_d   = '0;
      sh_d    = '0;
    end else if (bit_cyc) begin
      cnt_d = cnt_q + CW'(1);
      unique case (state_q)
        S_CMD: begin
          sh_d = sh_in[6:0];
          if (last8) begin
            cnt_d   = '0;
            state_d = S_ADDR;
            case (sh_in)
              8'h03:   kind_d  = K_RD;
              8'h0B:   kind_d  = K_FAST;
              8'h02:   kind_d  = K_WR;
              default: state_d = S_IGN;
            endcase
          end
        end
        S_ADDR: begin
          // only the low ADDR_BITS survive the 24-bit shift, giving the wrap
          addr_d = {addr_q[ADDR_BITS-2:0], spi.spi_mosi};
          if (cnt_q == CW'(23)) begin
            cnt_d = '0;
            if (kind_q == K_WR)                             state_d = S_WR;
            else if (kind_q == K_FAST && DUMMY_CYCLES > 0)  state_d = S_DUMMY;
            else                                            state_d = S_RD;
          end
        end
        S_DUMMY: begin
          if (cnt_q == CW'(DUMMY_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = S_RD;
          end
        end
        S_RD: begin
          if (last8) begin
            cnt_d  = '0;
            addr_d = addr_q + ADDR_BITS'(1);
          end
        end
        S_WR: begin
          sh_d = sh_in[6:0];
          if (last8) begin
            cnt_d  = '0;
            mem_we = 1'b1;
            addr_d = addr_q + ADDR_BITS'(1);
          end
        end
        S_IGN: cnt_d = cnt_q;
        default: cnt_d = cnt_q;
      endcase
    end
    if (load_en && spi.spi_select) begin
      mem_we = 1'b1;
      mem_wa = load_addr;
      mem_wd = load_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_CMD;
      kind_q  <= K_RD;
      cnt_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      armed_q <= armed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign spi.spi_miso = (state_q == S_RD) ? mem[addr_q][3'd7 - cnt_q[2:0]] : 1'b0;
  assign busy         = (state_q != S_CMD) || (cnt_q != '0);
endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: reads, fast read, writes, wrap, stall,
// abort, unknown command, dropped backdoor load and mid-read reset.
module tb_spi_ram_responder;
  logic       clk, rstn;
  logic       load_en;
  logic [7:0] load_addr, load_data;
  logic       busy;
  int         n_chk, n_fail;

  spi_ram_responder_if sif ();

  spi_ram_responder #(.ADDR_BITS(8), .DUMMY_CYCLES(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .spi       (sif.slave),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // One bit per cycle: miso is sampled in the cycle before the edge that takes mosi.
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit stall, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (stall && i == 3) begin
        repeat (5) begin
          @(negedge clk);
          sif.spi_clk_enable = 1'b0;
        end
        check("busy_in_stall", {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      sif.spi_select     = 1'b0;
      sif.spi_clk_enable = 1'b1;
      sif.spi_mosi       = tx[i];
      rx[i]              = sif.spi_miso;
    end
    @(posedge clk);
  endtask

  task automatic deselect();
    @(negedge clk);
    sif.spi_select = 1'b1; sif.spi_clk_enable = 1'b0; sif.spi_mosi = 1'b0;
    @(negedge clk);
  endtask

  task automatic header(input logic [7:0] cmd, input logic [23:0] a, input bit stall);
    logic [7:0] rx;
    xfer(cmd, 8, 1'b0, rx);
    xfer(a[23:16], 8, 1'b0, rx);
    xfer(a[15:8], 8, stall, rx);
    xfer(a[7:0], 8, 1'b0, rx);
  endtask

  logic [7:0] rx;
  logic [7:0] exp_stream [4];

  initial begin
    n_chk = 0; n_fail = 0;
    exp_stream[0] = 8'h93; exp_stream[1] = 8'h00; exp_stream[2] = 8'h10; exp_stream[3] = 8'h00;
    rstn = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    sif.spi_select = 1'b1; sif.spi_clk_enable = 1'b0; sif.spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, sif.spi_miso}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;

    load(8'h10, 8'h93); load(8'h11, 8'h00); load(8'h12, 8'h10); load(8'h13, 8'h00);
    load(8'hFF, 8'h3C); load(8'h00, 8'hC3); load(8'h20, 8'h11); load(8'h40, 8'hEE);

    // plain read: first data bit sampled in cycle 33
    header(8'h03, 24'h000010, 1'b0);
    check("rd_busy", {31'd0, busy}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      xfer(8'h00, 8, 1'b0, rx);
      check($sformatf("rd_byte%0d", b), {24'd0, rx}, {24'd0, exp_stream[b]});
    end
    deselect();
    check("desel_busy", {31'd0, busy}, 32'd0);

    // write two bytes then read them back
    header(8'h02, 24'h000040, 1'b0);
    xfer(8'hA5, 8, 1'b0, rx);
    xfer(8'h5A, 8, 1'b0, rx);
    deselect();
    header(8'h03, 24'h000040, 1'b0);
    xfer(8'h00, 8, 1'b0, rx); check("wr_rd0", {24'd0, rx}, 32'hA5);
    xfer(8'h00, 8, 1'b0, rx); check("wr_rd1", {24'd0, rx}, 32'h5A);
    deselect();

    // partial write byte discarded on deselect
    header(8'h02, 24'h000040, 1'b0);
    xfer(8'hF0, 4, 1'b0, rx);
    deselect();
    header(8'h03, 24'h000040, 1'b0);
    xfer(8'h00, 8, 1'b0, rx); check("partial_wr", {24'd0, rx}, 32'hA5);
    deselect();

    // address wrap, upper address bits ignored
    header(8'h03, 24'hABCDFF, 1'b0);
    xfer(8'h00, 8, 1'b0, rx); check("wrap_ff", {24'd0, rx}, 32'h3C);
    xfer(8'h00, 8, 1'b0, rx); check("wrap_00", {24'd0, rx}, 32'hC3);
    deselect();

    // fast read: 8 dummy cycles of zero, data from cycle 41
    header(8'h0B, 24'h000010, 1'b0);
    xfer(8'hFF, 8, 1'b0, rx); check("fast_dummy", {24'd0, rx}, 32'h00);
    xfer(8'h00, 8, 1'b0, rx); check("fast_byte0", {24'd0, rx}, 32'h93);
    xfer(8'h00, 8, 1'b0, rx); check("fast_byte1", {24'd0, rx}, 32'h00);
    deselect();

    // 5-cycle enable stall in the middle of the address
    header(8'h03, 24'h000010, 1'b1);
    for (int b = 0; b < 4; b++) begin
      xfer(8'h00, 8, 1'b0, rx);
      check($sformatf("stall_byte%0d", b), {24'd0, rx}, {24'd0, exp_stream[b]});
    end
    deselect();

    // unknown command, plus a backdoor load attempted while selected
    header(8'h9F, 24'h000010, 1'b0);
    check("ign_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    sif.spi_clk_enable = 1'b0; load_en = 1'b1; load_addr = 8'h20; load_data = 8'h77;
    @(negedge clk);
    load_en = 1'b0;
    for (int b = 0; b < 2; b++) begin
      xfer(8'hFF, 8, 1'b0, rx);
      check($sformatf("ign_miso%0d", b), {24'd0, rx}, 32'h00);
    end
    deselect();
    header(8'h03, 24'h000020, 1'b0);
    xfer(8'h00, 8, 1'b0, rx); check("load_dropped", {24'd0, rx}, 32'h11);
    deselect();

    // reset while streaming data
    header(8'h03, 24'h000010, 1'b0);
    @(negedge clk);
    sif.spi_clk_enable = 1'b0;
    check("pre_rst_miso", {31'd0, sif.spi_miso}, 32'd1);
    rstn = 1'b0;
    #1;
    check("rst_rd_miso", {31'd0, sif.spi_miso}, 32'd0);
    check("rst_rd_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    deselect();
    header(8'h03, 24'h000010, 1'b0);
    xfer(8'h00, 8, 1'b0, rx); check("post_rst0", {24'd0, rx}, 32'h93);
    xfer(8'h00, 8, 1'b0, rx); check("post_rst1", {24'd0, rx}, 32'h00);
    deselect();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
